// File: rtl/cpu_test_ctrl.sv
// rtl/cpu_test_ctrl.sv - CPU test-harness controller: reset sequencing, run-cycle counting, tohost result snooping
module cpu_test_ctrl #(
    parameter int                      DMEM_ADDR_WIDTH = 12,
    parameter int                      DMEM_DATA_WIDTH = 32,
    parameter int                      RST_CYCLES      = 2,
    parameter int                      TIMEOUT_CYCLES  = 100,
    parameter logic [DMEM_ADDR_WIDTH-1:0] TOHOST_ADDR  = 12'hFFC,
    parameter int                      CNT_WIDTH       = 32,
    parameter int                      HALT_ON_DONE    = 1
) (
    input  logic                       sysclk,
    input  logic                       rst,
    input  logic                       dmem_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DMEM_DATA_WIDTH-1:0] dmem_wdata,
    input  logic                       led,
    output logic                       cpu_rst,
    output logic                       running,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [DMEM_DATA_WIDTH-2:0] exit_code,
    output logic [CNT_WIDTH-1:0]       cycle_count,
    output logic [CNT_WIDTH-1:0]       led_toggles
);

    localparam int RST_EFF = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
    localparam int HOLD_W  = (RST_EFF < 2) ? 1 : $clog2(RST_EFF);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_EFF - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [DMEM_DATA_WIDTH-1:0] WDATA_ONE = DMEM_DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [HOLD_W-1:0]          hold_q, hold_d;
    logic [CNT_WIDTH-1:0]       cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]       toggles_q, toggles_d;
    logic [DMEM_DATA_WIDTH-2:0] exit_q, exit_d;
    logic                       led_q;

    logic tohost_hit;
    logic terminal;

    assign tohost_hit = dmem_we && (dmem_addr == TOHOST_ADDR);
    assign terminal   = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_HOLD;
            hold_q    <= '0;
            cycle_q   <= '0;
            toggles_q <= '0;
            exit_q    <= '0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cycle_q   <= cycle_d;
            toggles_q <= toggles_d;
            exit_q    <= exit_d;
            led_q     <= led;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        toggles_d = toggles_q;
        exit_d    = exit_q;
        case (state_q)
            S_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + 1'b1;
                end
                if (led && !led_q && (toggles_q != '1)) begin
                    toggles_d = toggles_q + 1'b1;
                end
                // Even-valued tohost stores are progress markers, not results.
                if (tohost_hit && dmem_wdata[0]) begin
                    if (dmem_wdata == WDATA_ONE) begin
                        state_d = S_PASS;
                    end else begin
                        state_d = S_FAIL;
                        exit_d  = dmem_wdata[DMEM_DATA_WIDTH-1:1];
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cycle_q == TO_LAST)) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    assign cpu_rst     = (state_q == S_HOLD) || ((HALT_ON_DONE != 0) && terminal);
    assign running     = (state_q == S_RUN);
    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign timeout     = (state_q == S_TIMEOUT);
    assign done        = pass || fail || timeout;
    assign exit_code   = exit_q;
    assign cycle_count = cycle_q;
    assign led_toggles = toggles_q;

endmodule
